uart_led_cmd: RTL and testbench

Command decoder between the UART receiver and transmitter of the LED board design. It consumes received bytes as single-cycle strobes, parses a small ASCII protocol that sets or queries the board LEDs, and streams reply bytes to the UART transmitter over a valid/ready handshake. It replaces the fixed byte-to-LED mapping with addressed, acknowledged control.

---
 rtl/uart_led_cmd_pkg.sv | 43 ++++
 rtl/uart_reply_seq.sv | 54 +++++
 rtl/uart_led_cmd.sv | 180 ++++++++++++++++++
 tb/tb_uart_led_cmd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_led_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART LED command decoder.
package uart_led_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H1,
        ST_H2,
        ST_T,
        ST_Q,
        ST_FLUSH,
        ST_REPLY
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_K  = 8'h4B;

    localparam int MAX_REPLY_LEN = 4;
    localparam int LEN_W         = $clog2(MAX_REPLY_LEN + 1);
    localparam int IDX_W         = $clog2(MAX_REPLY_LEN);

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Returns {valid, value}; accepts 0-9, A-F and a-f.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_reply_seq.sv
// Reply message buffer: loaded with up to four bytes, streams them out over valid/ready.
module uart_reply_seq
    import uart_led_cmd_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_load,
    input  logic [LEN_W-1:0]               i_len,
    input  logic [MAX_REPLY_LEN-1:0][7:0]  i_bytes,
    input  logic                           i_tx_ready,
    output logic                           o_tx_valid,
    output logic [7:0]                     o_tx_data,
    output logic                           o_done
);

    logic [MAX_REPLY_LEN-1:0][7:0] r_buf;
    logic [LEN_W-1:0]              r_len;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_valid;
    logic [7:0]                    r_data;
    logic                          w_fire;
    logic                          w_last;

    assign w_fire     = r_valid && i_tx_ready;
    assign w_last     = (LEN_W'(r_idx) + LEN_W'(1)) == r_len;
    assign o_done     = w_fire && w_last;
    assign o_tx_valid = r_valid;
    assign o_tx_data  = r_data;

    // The byte on o_tx_data only advances on a handshake, so it holds while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_buf   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_buf   <= i_bytes;
            r_len   <= i_len;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= i_bytes[0];
        end else if (w_fire) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_data <= r_buf[r_idx + IDX_W'(1)];
            end
        end
    end

endmodule

// File: rtl/uart_led_cmd.sv
// ASCII LED command parser ("Lhh", "?") with reply streaming and inter-byte timeout.
// Define UART_LED_CMD_ACK_EN to acknowledge successful L commands with "K\r\n".
module uart_led_cmd
    import uart_led_cmd_pkg::*;
#(
    parameter int CLK_HZ         = 27_000_000,
    parameter int N_LEDS         = 6,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int TIMEOUT_MS     = 100
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready,
    output logic [N_LEDS-1:0] o_led,
    output logic              o_err
);

    localparam int TMO_CYCLES = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TMO_W      = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [N_LEDS-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};
    localparam logic [MAX_REPLY_LEN-1:0][7:0] MSG_ERR = {8'h00, ASCII_LF, ASCII_CR, ASCII_E};
`ifdef UART_LED_CMD_ACK_EN
    localparam logic [MAX_REPLY_LEN-1:0][7:0] MSG_ACK = {8'h00, ASCII_LF, ASCII_CR, ASCII_K};
`endif

    state_t                        r_state;
    state_t                        w_next;
    logic [N_LEDS-1:0]             r_led_val;
    logic [N_LEDS-1:0]             r_led_drv;
    logic [3:0]                    r_hi;
    logic [3:0]                    r_lo;
    logic [TMO_W-1:0]              r_tmo;
    logic                          r_err;
    logic                          w_is_hex;
    logic [3:0]                    w_nib;
    logic                          w_is_term;
    logic [7:0]                    w_val;
    logic [7:0]                    w_led8;
    logic                          w_in_range;
    logic                          w_timed;
    logic                          w_expire;
    logic                          w_fail;
    logic                          w_load;
    logic [LEN_W-1:0]              w_len;
    logic [MAX_REPLY_LEN-1:0][7:0] w_bytes;
    logic                          w_err_set;
    logic                          w_led_we;
    logic                          w_done;

    assign {w_is_hex, w_nib} = hex_to_nibble(i_rx_data);
    assign w_is_term  = is_term(i_rx_data);
    assign w_val      = {r_hi, r_lo};
    assign w_led8     = 8'(r_led_val);
    assign w_in_range = (w_val >> N_LEDS) == 8'd0;
    assign w_timed    = r_state inside {ST_H1, ST_H2, ST_T, ST_Q, ST_FLUSH};
    assign w_expire   = w_timed && (r_tmo == '0) && !i_rx_valid;
    assign o_led      = r_led_drv;
    assign o_err      = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // A rejected terminator is equivalent to entering FLUSH and seeing it at once,
    // so it replies "E" directly instead of waiting for another terminator.
    always_comb begin
        w_next    = r_state;
        w_fail    = 1'b0;
        w_load    = 1'b0;
        w_len     = '0;
        w_bytes   = '0;
        w_err_set = 1'b0;
        w_led_we  = 1'b0;
        case (r_state)
            ST_IDLE: if (i_rx_valid) begin
                if (i_rx_data == ASCII_L)      w_next = ST_H1;
                else if (i_rx_data == ASCII_Q) w_next = ST_Q;
                else if (!w_is_term)           w_fail = 1'b1;
            end
            ST_H1: if (i_rx_valid) begin
                if (w_is_hex) w_next = ST_H2;
                else          w_fail = 1'b1;
            end
            ST_H2: if (i_rx_valid) begin
                if (w_is_hex) w_next = ST_T;
                else          w_fail = 1'b1;
            end
            ST_T: if (i_rx_valid) begin
                if (w_is_term && w_in_range) begin
                    w_led_we = 1'b1;
`ifdef UART_LED_CMD_ACK_EN
                    w_load  = 1'b1;
                    w_len   = LEN_W'(3);
                    w_bytes = MSG_ACK;
                    w_next  = ST_REPLY;
`else
                    w_next  = ST_IDLE;
`endif
                end else begin
                    w_fail = 1'b1;
                end
            end
            ST_Q: if (i_rx_valid) begin
                if (w_is_term) begin
                    w_load  = 1'b1;
                    w_len   = LEN_W'(4);
                    w_bytes = {ASCII_LF, ASCII_CR, nibble_to_hex(w_led8[3:0]), nibble_to_hex(w_led8[7:4])};
                    w_next  = ST_REPLY;
                end else begin
                    w_fail = 1'b1;
                end
            end
            ST_FLUSH: if (i_rx_valid) w_fail = 1'b1;
            ST_REPLY: begin
                if (i_rx_valid) w_err_set = 1'b1;
                if (w_done)     w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_fail) begin
            if (w_is_term) begin
                w_load    = 1'b1;
                w_len     = LEN_W'(3);
                w_bytes   = MSG_ERR;
                w_err_set = 1'b1;
                w_next    = ST_REPLY;
            end else begin
                w_next = ST_FLUSH;
            end
        end
        if (w_expire) begin
            w_next    = ST_IDLE;
            w_err_set = 1'b1;
        end
    end

    // Any received byte reloads the timer, so a byte arriving on the expiry cycle wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_led_val <= '0;
            r_led_drv <= LED_OFF;
            r_hi      <= 4'h0;
            r_lo      <= 4'h0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (w_led_we) begin
                r_led_val <= w_val[N_LEDS-1:0];
                r_led_drv <= (LED_ACTIVE_LOW != 0) ? ~w_val[N_LEDS-1:0] : w_val[N_LEDS-1:0];
            end
            if (i_rx_valid && w_is_hex && r_state == ST_H1) r_hi <= w_nib;
            if (i_rx_valid && w_is_hex && r_state == ST_H2) r_lo <= w_nib;
            if (i_rx_valid)
                r_tmo <= TMO_W'(TMO_CYCLES - 1);
            else if (w_timed && r_tmo != '0)
                r_tmo <= r_tmo - TMO_W'(1);
        end
    end

    uart_reply_seq u_reply (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_len      (w_len),
        .i_bytes    (w_bytes),
        .i_tx_ready (i_tx_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .o_done     (w_done)
    );

endmodule

// File: tb/tb_uart_led_cmd.sv
// Directed bench for uart_led_cmd: LED set/query, errors, timeout, drops and reset.
module tb_uart_led_cmd;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rxValid;
    logic [7:0] rxData;
    logic       txValid;
    logic [7:0] txData;
    logic       txReady;
    logic [5:0] led;
    logic       err;

    int checks    = 0;
    int errors    = 0;
    int errPulses = 0;
    int errBase   = 0;

    localparam logic [31:0] MSG_E = 32'h000A0D45;
    localparam logic [31:0] MSG_K = 32'h000A0D4B;

    always #5 clk = ~clk;

    uart_led_cmd #(
        .CLK_HZ         (100_000),
        .N_LEDS         (6),
        .LED_ACTIVE_LOW (1),
        .TIMEOUT_MS     (1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_rx_valid (rxValid),
        .i_rx_data  (rxData),
        .o_tx_valid (txValid),
        .o_tx_data  (txData),
        .i_tx_ready (txReady),
        .o_led      (led),
        .o_err      (err)
    );

    // Counts o_err cycles using the value held before each rising edge.
    always @(posedge clk) if (err) errPulses++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic applyString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    // Bytes of msg are sent low byte first; stallAt holds ready low 5 cycles on that byte.
    task automatic expectReply(input string tag, input logic [31:0] msg, input int n, input int stallAt);
        for (int i = 0; i < n; i++) begin
            int waitCycles = 0;
            while (!txValid && waitCycles < 20) begin
                @(negedge clk);
                waitCycles++;
            end
            checkOutput({tag, " valid"}, 32'(txValid), 32'd1);
            checkOutput({tag, " byte"}, 32'(txData), 32'(msg[8*i +: 8]));
            if (i == stallAt) begin
                repeat (5) begin
                    @(negedge clk);
                    checkOutput({tag, " stall"}, 32'({txValid, txData}), 32'({1'b1, msg[8*i +: 8]}));
                end
            end
            txReady = 1'b1;
            @(negedge clk);
            txReady = 1'b0;
        end
        checkOutput({tag, " end"}, 32'(txValid), 32'd0);
    endtask

    task automatic expectAck(input string tag);
`ifdef UART_LED_CMD_ACK_EN
        expectReply(tag, MSG_K, 3, -1);
`else
        repeat (2) @(negedge clk);
        checkOutput({tag, " silent"}, 32'(txValid), 32'd0);
`endif
    endtask

    initial begin
        rstN    = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        txReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst led", 32'(led), 32'h3F);
        checkOutput("rst txValid", 32'(txValid), 32'd0);
        checkOutput("rst txData", 32'(txData), 32'h00);
        checkOutput("rst err", 32'(err), 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        applyString("L2A\r");
        checkOutput("L2A led", 32'(led), 32'h15);
        expectAck("L2A");

        applyString("\n");
        repeat (3) @(negedge clk);
        checkOutput("lone LF", 32'(txValid), 32'd0);

        applyString("?\n");
        expectReply("query 2A", 32'h0A0D4132, 4, 1);

        errBase = errPulses;
        applyString("L40\r");
        checkOutput("range err pulse", 32'(err), 32'd1);
        expectReply("range", MSG_E, 3, -1);
        checkOutput("range led", 32'(led), 32'h15);
        checkOutput("range err count", 32'(errPulses - errBase), 32'd1);

        applyString("L3F\r");
        checkOutput("L3F led", 32'(led), 32'h00);
        expectAck("L3F");

        errBase = errPulses;
        applyString("LxZ12\r");
        expectReply("flush", MSG_E, 3, -1);
        checkOutput("flush err count", 32'(errPulses - errBase), 32'd1);

        errBase = errPulses;
        applyString("L1\r");
        expectReply("short", MSG_E, 3, -1);
        applyString("Z\r");
        expectReply("unknown", MSG_E, 3, -1);
        checkOutput("short/unknown err count", 32'(errPulses - errBase), 32'd2);

        applyString("L1b\r");
        checkOutput("L1b led", 32'(led), 32'h24);
        expectAck("L1b");
        applyString("?\r");
        expectReply("query 1B", 32'h0A0D4231, 4, -1);

        applyString("L3F\r");
        checkOutput("L3F again led", 32'(led), 32'h00);
        expectAck("L3F again");

        errBase = errPulses;
        applyString("L3");
        repeat (80) @(negedge clk);
        checkOutput("timeout early", 32'(errPulses - errBase), 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("timeout err", 32'(errPulses - errBase), 32'd1);
        checkOutput("timeout no tx", 32'(txValid), 32'd0);
        applyString("?\r");
        expectReply("query after timeout", 32'h0A0D4633, 4, -1);

        errBase = errPulses;
        applyString("?\r");
        applyStimulus(8'h58);
        expectReply("drop", 32'h0A0D4633, 4, -1);
        checkOutput("drop err count", 32'(errPulses - errBase), 32'd1);

        applyString("?\r");
        checkOutput("pre-reset valid", 32'(txValid), 32'd1);
        txReady = 1'b1;
        @(negedge clk);
        txReady = 1'b0;
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("mid-reply reset valid", 32'(txValid), 32'd0);
        checkOutput("mid-reply reset led", 32'(led), 32'h3F);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post-reset quiet", 32'(txValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
